// File: rtl/wb_scan_mailbox.sv
// Wishbone-to-scan mailbox: holds one CPU request stable until a tagged host response arrives.
// Optional response timeout is enabled by defining WB_SCAN_MAILBOX_TIMEOUT_EN.
module wb_scan_mailbox #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int SEQ_W     = 2,
  parameter int TIMEOUT_W = 8
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic [AW-1:0]    i_wb_adr,
  input  logic [DW-1:0]    i_wb_dat,
  input  logic [3:0]       i_wb_sel,
  input  logic             i_wb_we,
  input  logic             i_wb_cyc,
  output logic [DW-1:0]    o_wb_rdt,
  output logic             o_wb_ack,
  output logic [AW-1:0]    o_req_adr,
  output logic [DW-1:0]    o_req_dat,
  output logic [3:0]       o_req_sel,
  output logic             o_req_we,
  output logic             o_req_valid,
  output logic [SEQ_W-1:0] o_req_seq,
  input  logic [DW-1:0]    i_rsp_rdt,
  input  logic             i_rsp_valid,
  input  logic [SEQ_W-1:0] i_rsp_seq,
  input  logic             i_err_clr,
  output logic             o_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]       r_state;
  logic [AW-1:0]    r_adr;
  logic [DW-1:0]    r_dat;
  logic [3:0]       r_sel;
  logic             r_we;
  logic [SEQ_W-1:0] r_seq;
  logic [DW-1:0]    r_rdt;

  logic w_capture;
  logic w_rsp_hit;
  logic w_timeout;

  assign w_capture = (r_state == S_IDLE) && i_wb_cyc;
  // Only a response carrying the current tag counts; stale held responses fall through.
  assign w_rsp_hit = (r_state == S_PEND) && i_rsp_valid && (i_rsp_seq == r_seq);

`ifdef WB_SCAN_MAILBOX_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_cnt;
  logic [TIMEOUT_W-1:0] w_cnt_next;
  logic                 r_err;

  assign w_cnt_next = r_cnt + 1'b1;
  assign w_timeout  = (r_state == S_PEND) && (w_cnt_next == {TIMEOUT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_capture)
        r_cnt <= '0;
      else if (r_state == S_PEND)
        r_cnt <= w_cnt_next;
      // A simultaneous timeout beats a clear request.
      if (w_timeout && !w_rsp_hit)
        r_err <= 1'b1;
      else if (i_err_clr)
        r_err <= 1'b0;
    end
  end

  assign o_err = r_err;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = i_err_clr;
  assign w_timeout        = 1'b0;
  assign o_err            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_adr   <= '0;
      r_dat   <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_seq   <= '0;
      r_rdt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            r_adr   <= i_wb_adr;
            r_dat   <= i_wb_dat;
            r_sel   <= i_wb_sel;
            r_we    <= i_wb_we;
            r_seq   <= r_seq + 1'b1;
            r_state <= S_PEND;
          end
        end
        S_PEND: begin
          if (w_rsp_hit) begin
            r_rdt   <= i_rsp_rdt;
            r_state <= S_ACK;
          end else if (w_timeout) begin
            r_rdt   <= DW'(32'hDEAD_BEEF);
            r_state <= S_ACK;
          end
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_wb_ack    = (r_state == S_ACK);
  assign o_req_valid = (r_state == S_PEND);
  assign o_wb_rdt    = r_rdt;
  assign o_req_adr   = r_adr;
  assign o_req_dat   = r_dat;
  assign o_req_sel   = r_sel;
  assign o_req_we    = r_we;
  assign o_req_seq   = r_seq;

endmodule

// File: tb/tb_wb_scan_mailbox.sv
// Self-checking bench for wb_scan_mailbox (default build, no timeout).
// Expected read data is queued when a response is driven and checked when the ack appears.
module tb_wb_scan_mailbox;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_wb_adr, i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        i_wb_we, i_wb_cyc;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;
  logic [31:0] o_req_adr, o_req_dat;
  logic [3:0]  o_req_sel;
  logic        o_req_we, o_req_valid;
  logic [1:0]  o_req_seq;
  logic [31:0] i_rsp_rdt;
  logic        i_rsp_valid;
  logic [1:0]  i_rsp_seq;
  logic        i_err_clr;
  logic        o_err;

  int checks = 0;
  int failures = 0;
  int ack_count = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  wb_scan_mailbox dut (
    .clk(clk), .i_rst(i_rst),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
    .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc),
    .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack),
    .o_req_adr(o_req_adr), .o_req_dat(o_req_dat), .o_req_sel(o_req_sel),
    .o_req_we(o_req_we), .o_req_valid(o_req_valid), .o_req_seq(o_req_seq),
    .i_rsp_rdt(i_rsp_rdt), .i_rsp_valid(i_rsp_valid), .i_rsp_seq(i_rsp_seq),
    .i_err_clr(i_err_clr), .o_err(o_err)
  );

  // Ack monitor: every ack must match the oldest queued response.
  always @(posedge clk) begin
    #1;
    if (o_wb_ack === 1'b1) begin
      ack_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL ack_unexpected actual_rdt=%h required=no_ack", o_wb_rdt);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (o_wb_rdt !== e) begin
          failures++;
          $display("FAIL ack_rdt actual=%h required=%h", o_wb_rdt, e);
        end else
          $display("ack seq=%0d rdt=%h", o_req_seq, o_wb_rdt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we);
    @(negedge clk);
    i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel; i_wb_we = we; i_wb_cyc = 1'b1;
    @(negedge clk);
  endtask

  task automatic respond(input logic [1:0] seq, input logic [31:0] rdt);
    i_rsp_valid = 1'b1; i_rsp_seq = seq; i_rsp_rdt = rdt;
    exp_q.push_back(rdt);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst = 1'b1; i_wb_cyc = 1'b0; i_rsp_valid = 1'b0;
    @(negedge clk);
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({o_wb_ack, o_req_valid, o_err, o_req_seq} !== 5'b0 || o_wb_rdt !== 32'h0 ||
        o_req_adr !== 32'h0 || o_req_dat !== 32'h0 || o_req_sel !== 4'h0 || o_req_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_state actual=ack%b valid%b err%b seq%0d rdt%h adr%h required=all_zero",
               o_wb_ack, o_req_valid, o_err, o_req_seq, o_wb_rdt, o_req_adr);
    end
  endtask

  task automatic test_read();
    issue(32'h100, 32'h0, 4'hF, 1'b0);
    checks++;
    if (o_req_valid !== 1'b1 || o_req_seq !== 2'd1 || o_req_adr !== 32'h100 || o_req_we !== 1'b0) begin
      failures++;
      $display("FAIL read_capture actual=valid%b seq%0d adr%h we%b required=valid1 seq1 adr00000100 we0",
               o_req_valid, o_req_seq, o_req_adr, o_req_we);
    end
    respond(2'd1, 32'h1234_5678);
    checks++;
    if (o_wb_ack !== 1'b1 || o_wb_rdt !== 32'h1234_5678 || o_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL read_ack actual=ack%b rdt%h valid%b required=ack1 rdt12345678 valid0",
               o_wb_ack, o_wb_rdt, o_req_valid);
    end
    i_wb_cyc = 1'b0;
    @(negedge clk);
    checks++;
    if (o_wb_ack !== 1'b0 || o_wb_rdt !== 32'h1234_5678) begin
      failures++;
      $display("FAIL read_ack_single actual=ack%b rdt%h required=ack0 rdt12345678", o_wb_ack, o_wb_rdt);
    end
  endtask

  task automatic test_stale();
    int acks_before;
    acks_before = ack_count;
    issue(32'h104, 32'h0, 4'hF, 1'b0);
    checks++;
    if (o_req_seq !== 2'd2 || o_req_valid !== 1'b1) begin
      failures++;
      $display("FAIL stale_capture actual=seq%0d valid%b required=seq2 valid1", o_req_seq, o_req_valid);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (ack_count !== acks_before || o_req_valid !== 1'b1) begin
      failures++;
      $display("FAIL stale_ignored actual=acks%0d valid%b required=acks%0d valid1",
               ack_count, o_req_valid, acks_before);
    end
    respond(2'd2, 32'hCAFE_F00D);
    checks++;
    if (o_wb_ack !== 1'b1 || ack_count !== acks_before + 1) begin
      failures++;
      $display("FAIL stale_match_ack actual=ack%b acks%0d required=ack1 acks%0d",
               o_wb_ack, ack_count, acks_before + 1);
    end
    i_wb_cyc = 1'b0; i_rsp_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    issue(32'h200, 32'hA5A5_A5A5, 4'b0011, 1'b1);
    checks++;
    if (o_req_adr !== 32'h200 || o_req_dat !== 32'hA5A5_A5A5 || o_req_sel !== 4'b0011 ||
        o_req_we !== 1'b1 || o_req_seq !== 2'd3 || o_req_valid !== 1'b1) begin
      failures++;
      $display("FAIL write_capture actual=adr%h dat%h sel%b we%b seq%0d required=adr00000200 datA5A5A5A5 sel0011 we1 seq3",
               o_req_adr, o_req_dat, o_req_sel, o_req_we, o_req_seq);
    end
    i_wb_dat = 32'h0; i_wb_adr = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if (o_wb_ack !== 1'b0 || o_req_dat !== 32'hA5A5_A5A5 || o_req_adr !== 32'h200) begin
      failures++;
      $display("FAIL write_hold actual=ack%b dat%h adr%h required=ack0 datA5A5A5A5 adr00000200",
               o_wb_ack, o_req_dat, o_req_adr);
    end
    respond(2'd3, 32'h0000_0055);
    checks++;
    if (o_wb_ack !== 1'b1) begin
      failures++;
      $display("FAIL write_ack actual=%b required=1", o_wb_ack);
    end
    i_wb_cyc = 1'b0; i_rsp_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [1:0] exp_seq;
    int acks_before;
    do_reset();
    acks_before = ack_count;
    exp_seq = 2'd0;
    for (int i = 0; i < 5; i++) begin
      exp_seq = exp_seq + 2'd1;
      issue(32'h300 + 32'(i * 4), 32'(i), 4'hF, 1'b0);
      checks++;
      if (o_req_seq !== exp_seq || o_req_valid !== 1'b1) begin
        failures++;
        $display("FAIL wrap_seq%0d actual=%0d required=%0d", i, o_req_seq, exp_seq);
      end
      respond(exp_seq, 32'h1000_0000 + 32'(i));
      i_wb_cyc = 1'b0; i_rsp_valid = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (ack_count !== acks_before + 5) begin
      failures++;
      $display("FAIL wrap_ack_count actual=%0d required=%0d", ack_count - acks_before, 5);
    end
  endtask

  task automatic test_reset_pend();
    int acks_before;
    issue(32'h400, 32'h0, 4'hF, 1'b0);
    acks_before = ack_count;
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0; i_wb_cyc = 1'b0;
    checks++;
    if (o_req_valid !== 1'b0 || o_req_seq !== 2'd0 || o_wb_ack !== 1'b0 || o_req_adr !== 32'h0) begin
      failures++;
      $display("FAIL reset_pend actual=valid%b seq%0d ack%b adr%h required=valid0 seq0 ack0 adr0",
               o_req_valid, o_req_seq, o_wb_ack, o_req_adr);
    end
    i_rsp_valid = 1'b1; i_rsp_seq = 2'd1; i_rsp_rdt = 32'hBAD0_BAD0;
    repeat (4) @(negedge clk);
    checks++;
    if (ack_count !== acks_before || o_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp_ignored actual=acks%0d valid%b required=acks%0d valid0",
               ack_count, o_req_valid, acks_before);
    end
    i_rsp_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    i_rst = 1'b1; i_wb_adr = '0; i_wb_dat = '0; i_wb_sel = '0; i_wb_we = 1'b0; i_wb_cyc = 1'b0;
    i_rsp_rdt = '0; i_rsp_valid = 1'b0; i_rsp_seq = '0; i_err_clr = 1'b0;
    test_reset();
    test_read();
    test_stale();
    test_write();
    test_wrap();
    test_reset_pend();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
